// File: rtl/fifo_rd_stream_pkg.sv
// Shared defaults for the FIFO read-side stream adapter: data width, burst length, queue depth.
// No logic; the width helper lets a single-beat burst still carry a 1-bit counter.
package fifo_rd_stream_pkg;

  localparam int DEF_DW        = 16;
  localparam int DEF_BURST_LEN = 8;
  localparam int Q_DEPTH       = 3;

  function automatic int beat_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_skid_q3.sv
// 3-entry in-order register queue; head always at entry 0, visible the cycle after push.
// No backpressure of its own: the caller keeps pushes within the free space.
module skid_q3 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   occ
);

  logic [W-1:0] mem     [3];
  logic [W-1:0] mem_nxt [3];
  logic [1:0]   occ_nxt;

  // Pop shifts toward the head first, so a same-cycle push lands behind the surviving entries.
  always_comb begin
    mem_nxt = mem;
    occ_nxt = occ;
    if (pop && (occ != 2'd0)) begin
      mem_nxt[0] = mem[1];
      mem_nxt[1] = mem[2];
      occ_nxt    = occ - 2'd1;
    end
    if (push && (occ_nxt != 2'd3)) begin
      for (int i = 0; i < 3; i++) begin
        if (occ_nxt == 2'(i)) mem_nxt[i] = din;
      end
      occ_nxt = occ_nxt + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= 2'd0;
      for (int i = 0; i < 3; i++) mem[i] <= '0;
    end else begin
      occ <= occ_nxt;
      for (int i = 0; i < 3; i++) mem[i] <= mem_nxt[i];
    end
  end

  assign dout = mem[0];

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read port to valid/ready stream with burst framing; first word visible 2 cycles after its read.
// Consumer stalls hold m_data; reads stop once buffered plus in-flight words reach the queue depth.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int  DW        = DEF_DW,
  parameter int  BURST_LEN = DEF_BURST_LEN,
  localparam int BW        = beat_w(BURST_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          fifo_empty,
  output logic          fifo_rd_en,
  input  logic [DW-1:0] fifo_rd_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic [BW-1:0] beat_idx,
  output logic [31:0]   word_cnt
);

  localparam logic [BW-1:0] LAST_IDX = BW'(BURST_LEN - 1);

  logic [1:0] occ;
  logic       inflight;
  logic       xfer;

  // Counting the in-flight word reserves its slot, so the issue decision never looks at m_ready.
  assign fifo_rd_en = !rst && en && !fifo_empty &&
                      ((3'(occ) + 3'(inflight)) < 3'(Q_DEPTH));

  assign m_valid = (occ != 2'd0);
  assign xfer    = m_valid && m_ready;
  assign m_last  = m_valid && (beat_idx == LAST_IDX);

  skid_q3 #(.W(DW)) u_q (
    .clk  (clk),
    .rst  (rst),
    .push (inflight),
    .pop  (xfer),
    .din  (fifo_rd_data),
    .dout (m_data),
    .occ  (occ)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
      beat_idx <= '0;
      word_cnt <= 32'd0;
    end else begin
      inflight <= fifo_rd_en;
      if (xfer) begin
        word_cnt <= word_cnt + 32'd1;
        beat_idx <= (beat_idx == LAST_IDX) ? '0 : beat_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: FIFO model, timestamped word-queue reference model, per-cycle compare.
module tb_fifo_rd_stream;

  localparam int BL = 8;

  logic        clk = 1'b0;
  logic        rst, en, m_ready;
  logic        fifo_empty = 1'b1;
  logic [15:0] fifo_rd_data = 16'd0;

  logic        fifo_rd_en, m_valid, m_last;
  logic [15:0] m_data;
  logic [2:0]  beat_idx;
  logic [31:0] word_cnt;

  logic        fifo_rd_en1, m_valid1, m_last1;
  logic [15:0] m_data1;
  logic [0:0]  beat_idx1;
  logic [31:0] word_cnt1;

  fifo_rd_stream #(.DW(16), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .beat_idx(beat_idx), .word_cnt(word_cnt)
  );

  // Same inputs, single-beat bursts: flow is identical, only framing differs.
  fifo_rd_stream #(.DW(16), .BURST_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en1),
    .fifo_rd_data(fifo_rd_data), .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1),
    .m_last(m_last1), .beat_idx(beat_idx1), .word_cnt(word_cnt1)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // FIFO contents and load requests (stimulus only posts requests; the FIFO process applies them).
  logic [15:0] fifo_q[$];
  logic [15:0] ld_base = 16'd0;
  int          ld_n = 0, ld_seq = 0, ld_seen = 0;

  task automatic load(input logic [15:0] base, input int n);
    ld_base = base;
    ld_n    = n;
    ld_seq++;
  endtask

  // Reference model: every word read and not yet consumed, stamped with the cycle it becomes visible.
  typedef struct { logic [15:0] d; int av; } ent_t;
  ent_t        mq[$];
  logic [31:0] n = 32'd0;

  logic        exp_rd_en, exp_valid, exp_last;
  logic [15:0] exp_data;
  int          exp_idx;

  task automatic calc();
    exp_rd_en = !rst && en && (fifo_q.size() != 0) && (mq.size() < 3);
    exp_valid = (mq.size() != 0) && (mq[0].av <= cyc);
    exp_data  = exp_valid ? mq[0].d : 16'd0;
    exp_idx   = int'(n % BL);
    exp_last  = exp_valid && (exp_idx == BL - 1);
  endtask

  always @(posedge clk) begin
    calc();
    if (rst) begin
      mq.delete();
      n = 32'd0;
    end else begin
      if (exp_valid && m_ready) begin
        void'(mq.pop_front());
        n = n + 32'd1;
      end
      if (exp_rd_en) mq.push_back(ent_t'{d: fifo_q[0], av: cyc + 2});
    end
    if (rst) fifo_q.delete();
    else if (fifo_rd_en && fifo_q.size() != 0) fifo_rd_data <= fifo_q.pop_front();
    if (ld_seq != ld_seen) begin
      for (int i = 0; i < ld_n; i++) fifo_q.push_back(ld_base + 16'(i));
      ld_seen = ld_seq;
    end
    fifo_empty <= (fifo_q.size() == 0);
    cyc++;
  end

  typedef struct { logic [15:0] d; logic last; logic [2:0] idx; logic [31:0] cnt; logic last1; } beat_t;
  beat_t blog[$];
  int    first_rd = -1, first_v = -1;

  always @(negedge clk) begin
    calc();
    chk("rd_en", fifo_rd_en, exp_rd_en);
    chk("valid", m_valid, exp_valid);
    chk("last", m_last, exp_last);
    chk("beat_idx", beat_idx, 64'(exp_idx));
    chk("word_cnt", word_cnt, n);
    if (exp_valid) chk("data", m_data, exp_data);
    chk("bl1_rd_en", fifo_rd_en1, exp_rd_en);
    chk("bl1_valid", m_valid1, exp_valid);
    chk("bl1_last", m_last1, exp_valid);
    chk("bl1_beat_idx", beat_idx1, 0);
    chk("bl1_word_cnt", word_cnt1, n);
    if (exp_valid) chk("bl1_data", m_data1, exp_data);
    if (fifo_rd_en && first_rd < 0) first_rd = cyc;
    if (m_valid && first_v < 0) first_v = cyc;
    if (m_valid && m_ready) blog.push_back(beat_t'{d: m_data, last: m_last, idx: beat_idx,
                                                   cnt: word_cnt, last1: m_last1});
  end

  initial begin
    int b0, b1, nl1;
    bit hit;
    rst = 1'b1; en = 1'b1; m_ready = 1'b0;
    load(16'hDEAD, 1);
    @(posedge clk); #1;
    chk("rst_rd_en_forced", fifo_rd_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_beat_idx", beat_idx, 0);
    @(posedge clk); #2;
    rst = 1'b0;

    // 1: full-rate stream of 16 words
    b0 = blog.size();
    load(16'h0001, 16); m_ready = 1'b1;
    repeat (25) @(posedge clk);
    #2;
    chk("t1_beats", 64'(blog.size() - b0), 16);
    nl1 = 0;
    for (int i = 0; i < 16; i++) begin
      if (b0 + i < blog.size()) begin
        chk($sformatf("t1_data%0d", i), blog[b0+i].d, 64'(i + 1));
        chk($sformatf("t1_last%0d", i), blog[b0+i].last, 64'(i == 7 || i == 15));
        nl1 += int'(blog[b0+i].last1);
      end
    end
    chk("t1_word_cnt", word_cnt, 16);
    chk("t1_latency", 64'(first_v - first_rd), 2);
    chk("t6_last_every_beat", 64'(nl1), 16);
    chk("t6_word_cnt", word_cnt1, 16);

    // 2: consumer stall for cycles 5..9
    b0 = blog.size();
    load(16'h0001, 8);
    for (int c = 0; c < 20; c++) begin
      m_ready = !(c >= 5 && c <= 9);
      if (c == 7) begin
        #1;
        chk("t2_hold_valid", m_valid, 1);
        chk("t2_hold_data", m_data, 16'h0003);
        #1;
      end
      if (c == 9) begin
        #1;
        chk("t2_rd_stopped", fifo_rd_en, 0);
        chk("t2_fifo_left", 64'(fifo_q.size()), 3);
        #1;
      end
      @(posedge clk); #2;
    end
    chk("t2_beats", 64'(blog.size() - b0), 8);
    for (int i = 0; i < 8; i++) begin
      if (b0 + i < blog.size()) begin
        chk($sformatf("t2_data%0d", i), blog[b0+i].d, 64'(i + 1));
        chk($sformatf("t2_idx%0d", i), blog[b0+i].idx, 64'(i));
      end
    end
    chk("t2_word_cnt", word_cnt, 24);

    // 3: empty gap inside a burst
    b0 = blog.size();
    for (int c = 0; c < 26; c++) begin
      if (c == 0) load(16'h0031, 3);
      if (c == 12) load(16'h0034, 5);
      if (c == 9) begin
        #1;
        chk("t3_gap_valid", m_valid, 0);
        #1;
      end
      @(posedge clk); #2;
    end
    chk("t3_beats", 64'(blog.size() - b0), 8);
    for (int i = 0; i < 8; i++) begin
      if (b0 + i < blog.size()) begin
        chk($sformatf("t3_idx%0d", i), blog[b0+i].idx, 64'(i));
        chk($sformatf("t3_last%0d", i), blog[b0+i].last, 64'(i == 7));
        chk($sformatf("t3_data%0d", i), blog[b0+i].d, 64'(16'h0031 + i));
      end
    end

    // 4: en dropped with 6 words still in the FIFO
    b0 = blog.size();
    load(16'h0041, 10);
    hit = 1'b0;
    for (int c = 0; c < 30 && !hit; c++) begin
      @(posedge clk); #2;
      if (fifo_q.size() <= 6) hit = 1'b1;
    end
    chk("t4_reached", 64'(hit), 1);
    en = 1'b0;
    #1;
    chk("t4_rd_en_drop", fifo_rd_en, 0);
    b1 = blog.size();
    repeat (10) @(posedge clk);
    #2;
    chk("t4_tail_le4", 64'((blog.size() - b1) <= 4), 1);
    chk("t4_fifo_kept", 64'(fifo_q.size()), 6);
    en = 1'b1;
    repeat (14) @(posedge clk);
    #2;
    chk("t4_total", 64'(blog.size() - b0), 10);
    chk("t4_word_cnt", word_cnt, 42);

    // 5: reset with two words buffered and one in flight
    m_ready = 1'b0;
    load(16'h0051, 10);
    repeat (4) @(posedge clk);
    #1;
    chk("t5_pre_valid", m_valid, 1);
    chk("t5_pre_cnt", word_cnt, 42);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_valid", m_valid, 0);
    chk("t5_word_cnt", word_cnt, 0);
    chk("t5_beat_idx", beat_idx, 0);
    #1;
    rst = 1'b0; m_ready = 1'b1;
    b0 = blog.size();
    load(16'h0061, 3);
    repeat (8) @(posedge clk);
    #2;
    chk("t5_beats", 64'(blog.size() - b0), 3);
    if (blog.size() >= b0 + 3) begin
      chk("t5_first_idx", blog[b0].idx, 0);
      chk("t5_first_data", blog[b0].d, 16'h0061);
      chk("t5_third_cnt", blog[b0+2].cnt, 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
